// File: rtl/mem_responder.sv
// Single-outstanding memory responder: IDLE/WAIT/RESP handshake over a 32-bit word store.
// Define MEM_RESPONDER_ADDR_CHECK_EN to flag (and not write) accesses outside the BASE_ADDR window.
module mem_responder #(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned IDX_LSB   = 2;
    localparam int unsigned IDX_MSB   = DEPTH_LOG2 + 1;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    // Transaction fields: live inputs on the grant cycle, captured copies afterwards.
    logic [31:0]           t_addr;
    logic                  t_we;
    logic [3:0]            t_be;
    logic [31:0]           t_wdata;
    logic [DEPTH_LOG2-1:0] t_idx;
    logic                  txn_err_c;
    logic                  commit_c;
    logic                  mem_we_c;

    assign gnt_o = req_i && (state_q == S_IDLE);

    always_comb begin
        t_addr  = addr_q;
        t_we    = we_q;
        t_be    = be_q;
        t_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            t_addr  = addr_i;
            t_we    = we_i;
            t_be    = be_i;
            t_wdata = wdata_i;
        end
    end

    assign t_idx = t_addr[IDX_MSB:IDX_LSB];

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    assign txn_err_c = (t_addr[31:IDX_MSB+1] != BASE_ADDR[31:IDX_MSB+1]);
    logic unused_addr;
    assign unused_addr = ^t_addr[1:0];
`else
    // Upper bits alias onto the window; only the word index matters.
    assign txn_err_c = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{t_addr[31:IDX_MSB+1], t_addr[1:0], BASE_ADDR};
`endif

    // Next-state, capture and response generation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rvalid_d = 1'b0;
        rdata_d  = 32'd0;
        err_d    = 1'b0;
        commit_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (gnt_o) begin
                    addr_d  = addr_i;
                    we_d    = we_i;
                    be_d    = be_i;
                    wdata_d = wdata_i;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d  = S_RESP;
                        commit_c = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = S_RESP;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Response registers are loaded on the edge that enters RESP.
        if (commit_c) begin
            rvalid_d = 1'b1;
            if (txn_err_c) begin
                err_d = 1'b1;
            end else if (!t_we) begin
                rdata_d = mem_q[t_idx];
            end
        end
    end

    // An active reset must never let a pending write land in storage.
    assign mem_we_c = commit_c && t_we && !txn_err_c && reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 32'd0;
            we_q     <= 1'b0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (t_be[b]) begin
                    mem_q[t_idx][8*b +: 8] <= t_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed and random transactions on a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance.
module tb_mem_responder;

    localparam logic [31:0] BASE = 32'h0010_0000;
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        req   [2];
    logic [31:0] addr  [2];
    logic        we    [2];
    logic [3:0]  be    [2];
    logic [31:0] wdata [2];
    logic        gnt   [2];
    logic        rvalid[2];
    logic [31:0] rdata [2];
    logic        err   [2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [2][256];

    mem_responder #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .req_i(req[0]), .addr_i(addr[0]), .we_i(we[0]),
        .be_i(be[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .err_o(err[0])
    );

    mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .req_i(req[1]), .addr_i(addr[1]), .we_i(we[1]),
        .be_i(be[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .err_o(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-masked word store with out-of-window error when checking is built in.
    function automatic void model(input int d, input logic w, input logic [31:0] a,
                                  input logic [3:0] b, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic e);
        int          idx;
        logic [31:0] mask;
        idx  = int'(a[9:2]);
        mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        e    = CHECK && (a[31:10] != BASE[31:10]);
        rd   = 32'd0;
        if (!e) begin
            if (w) ref_mem[d][idx] = (ref_mem[d][idx] & ~mask) | (wd & mask);
            else   rd = ref_mem[d][idx];
        end
    endfunction

    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e,
                       output int lat);
        int n;
        int g;
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
        #1;
        n = 0;
        while (gnt[d] !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        g = cyc;
        @(negedge clk);
        req[d] = 1'b0; we[d] = 1'($urandom); addr[d] = $urandom;
        be[d] = 4'($urandom); wdata[d] = $urandom;
        #1;
        n = 0;
        while (rvalid[d] !== 1'b1 && n < 50) begin
            chk("idle_quiet", {31'd0, err[d]} | rdata[d], 32'd0);
            @(negedge clk); #1; n++;
        end
        lat = (rvalid[d] === 1'b1) ? (cyc - g) : -1;
        rd  = rdata[d];
        e   = err[d];
    endtask

    task automatic run(input string tag, input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd);
        logic [31:0] rd, exp_rd;
        logic        e, exp_e;
        int          lat;
        model(d, w, a, b, wd, exp_rd, exp_e);
        txn(d, w, a, b, wd, rd, e, lat);
        chk({tag, "_lat"},   32'(lat), (d == 0) ? 32'd3 : 32'd1);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"},   {31'd0, e}, {31'd0, exp_e});
    endtask

    initial begin
        int          gc[$];
        int          rc[$];
        int          t0;
        int          seen;
        logic [31:0] exp7, dummy, a, old5;
        logic        de;

        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'd0; be[d] = 4'd0; wdata[d] = 32'd0;
        end
        #21;
        for (int d = 0; d < 2; d++) begin
            chk("rst_rvalid", {31'd0, rvalid[d]}, 32'd0);
            chk("rst_rdata", rdata[d], 32'd0);
            chk("rst_err", {31'd0, err[d]}, 32'd0);
            req[d] = 1'b1; #1;
            chk("rst_gnt", {31'd0, gnt[d]}, 32'd1);
            req[d] = 1'b0; #1;
            chk("rst_gnt_low", {31'd0, gnt[d]}, 32'd0);
        end
        @(negedge clk); reset_n = 1'b1;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                run("preload", d, 1'b1, BASE + 32'(4 * i), 4'hF, $urandom);

        run("wr_deadbeef", 0, 1'b1, 32'h0010_0004, 4'hF, 32'hDEAD_BEEF);
        run("rd_deadbeef", 0, 1'b0, 32'h0010_0004, 4'h0, 32'd0);
        chk("deadbeef_ref", ref_mem[0][1], 32'hDEAD_BEEF);

        run("pre_idx2", 0, 1'b1, 32'h0010_0008, 4'hF, 32'h1122_3344);
        run("be_0101", 0, 1'b1, 32'h0010_0008, 4'b0101, 32'hAABB_CCDD);
        run("rd_idx2", 0, 1'b0, 32'h0010_0008, 4'h0, 32'd0);
        chk("merge_ref", ref_mem[0][2], 32'h11BB_33DD);

        run("rd_alias", 0, 1'b0, 32'h0020_0000, 4'h0, 32'd0);

        run("be_none", 0, 1'b1, BASE + 32'd12, 4'b0000, 32'h5A5A_5A5A);
        run("rd_be_none", 0, 1'b0, BASE + 32'd12, 4'h0, 32'd0);

        // Three back-to-back reads with req held high.
        model(0, 1'b0, BASE + 32'd28, 4'h0, 32'd0, exp7, de);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = BASE + 32'd28; be[0] = 4'h0; #1;
        t0 = cyc;
        for (int k = 0; k < 14; k++) begin
            if (gnt[0] === 1'b1) gc.push_back(cyc - t0);
            if (rvalid[0] === 1'b1) begin
                rc.push_back(cyc - t0);
                chk("b2b_rdata", rdata[0], exp7);
            end
            @(negedge clk);
            if (gc.size() == 3) req[0] = 1'b0;
            #1;
        end
        chk("b2b_ngnt", 32'(gc.size()), 32'd3);
        chk("b2b_nrv", 32'(rc.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_gnt_cyc", (i < gc.size()) ? 32'(gc[i]) : 32'hFFFF_FFFF, 32'(4 * i));
            chk("b2b_rv_cyc", (i < rc.size()) ? 32'(rc[i]) : 32'hFFFF_FFFF, 32'(4 * i + 3));
        end

        run("w0_write", 1, 1'b1, BASE + 32'd40, 4'hF, 32'hCAFE_F00D);
        run("w0_read", 1, 1'b0, BASE + 32'd40, 4'h0, 32'd0);

        // Reset pulse in WAIT aborts the write.
        old5 = ref_mem[0][5];
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = BASE + 32'd20; be[0] = 4'hF; wdata[0] = ~old5; #1;
        chk("abort_gnt", {31'd0, gnt[0]}, 32'd1);
        @(negedge clk); req[0] = 1'b0; #1;
        reset_n = 1'b0; #1;
        chk("abort_rvalid", {31'd0, rvalid[0]}, 32'd0);
        chk("abort_rdata", rdata[0], 32'd0);
        @(negedge clk); reset_n = 1'b1; #1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (rvalid[0] === 1'b1) seen++;
            @(negedge clk); #1;
        end
        chk("abort_no_rvalid", 32'(seen), 32'd0);
        req[0] = 1'b1; we[0] = 1'b0; #1;
        chk("abort_idle_gnt", {31'd0, gnt[0]}, 32'd1);
        req[0] = 1'b0; #1;
        run("abort_rd_old", 0, 1'b0, BASE + 32'd20, 4'h0, 32'd0);
        chk("abort_ref", ref_mem[0][5], old5);

        for (int k = 0; k < 110; k++) begin
            int d;
            d = (k < 80) ? 0 : 1;
            a = (($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FC00) : BASE)
                | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
            run("rand", d, 1'($urandom), a, 4'($urandom_range(0, 15)), $urandom);
        end
        dummy = 32'd0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
